// File: rtl/cic_upsample.sv
// rtl/cic_upsample.sv - CIC interpolator: input-rate comb section, zero-stuff by R, clk-rate integrators
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   in_valid   input sample present
//   in_ready   block can accept a sample this cycle
//   in_data    signed WIDTH_IN input sample
//   out_valid  one-cycle strobe, out_data is a new output sample
//   out_data   signed WIDTH_OUT interpolated sample

module cic_upsample #(
    parameter int WIDTH_IN  = 16,
    parameter int R         = 8,
    parameter int M         = 1,
    parameter int STAGES    = 3,
    localparam int WIDTH_OUT = WIDTH_IN + STAGES * $clog2(R * M)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  in_data,
    output logic                 out_valid,
    output logic [WIDTH_OUT-1:0] out_data
);

    localparam int PW = $clog2(R);
    localparam logic [PW-1:0] PHASE_LAST = PW'(R - 1);

    // Comb delay lines, one M-deep line per stage; index 0 is the newest entry.
    logic [WIDTH_OUT-1:0] dly_q   [STAGES][M];
    logic [WIDTH_OUT-1:0] dly_d   [STAGES][M];
    logic [WIDTH_OUT-1:0] comb_q;
    logic [WIDTH_OUT-1:0] comb_d;
    logic [WIDTH_OUT-1:0] integ_q [STAGES];
    logic [WIDTH_OUT-1:0] integ_d [STAGES];
    logic [PW-1:0]        phase_q;
    logic [PW-1:0]        phase_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 out_valid_q;
    logic                 out_valid_d;

    // Comb chain: c[0] is the sign-extended input, c[STAGES] the comb result.
    logic [WIDTH_OUT-1:0] c [STAGES+1];
    logic [WIDTH_OUT-1:0] x;
    logic                 tick;
    logic                 accept;

    assign tick     = busy_q;
    // A new sample may land on the last tick of the current one so the
    // integrators see a continuous zero-stuffed stream.
    assign in_ready = !busy_q || (phase_q == PHASE_LAST);
    assign accept   = in_valid && in_ready;

    always_comb begin
        c[0] = {{(WIDTH_OUT - WIDTH_IN){in_data[WIDTH_IN-1]}}, in_data};
        for (int s = 0; s < STAGES; s++) begin
            c[s+1] = c[s] - dly_q[s][M-1];
        end
    end

    always_comb begin
        dly_d       = dly_q;
        comb_d      = comb_q;
        integ_d     = integ_q;
        phase_d     = phase_q;
        busy_d      = busy_q;
        out_valid_d = tick;
        x           = '0;

        if (tick) begin
            // Zero-stuffing: the comb output enters only on phase 0.
            x = (phase_q == '0) ? comb_q : '0;
            integ_d[0] = integ_q[0] + x;
            for (int j = 1; j < STAGES; j++) begin
                integ_d[j] = integ_q[j] + integ_q[j-1];
            end
            phase_d = phase_q + PW'(1);
            if (phase_q == PHASE_LAST) begin
                busy_d = 1'b0;
            end
        end

        if (accept) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int k = M - 1; k > 0; k--) begin
                    dly_d[s][k] = dly_q[s][k-1];
                end
                dly_d[s][0] = c[s];
            end
            comb_d  = c[STAGES];
            phase_d = '0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                for (int k = 0; k < M; k++) begin
                    dly_q[s][k] <= '0;
                end
                integ_q[s] <= '0;
            end
            comb_q      <= '0;
            phase_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            dly_q       <= dly_d;
            integ_q     <= integ_d;
            comb_q      <= comb_d;
            phase_q     <= phase_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = integ_q[STAGES-1];

endmodule

// File: tb/tb_cic_upsample.sv
// tb/tb_cic_upsample.sv - directed self-checking bench for cic_upsample (R=8, M=1, STAGES=3)

module tb_cic_upsample;

    localparam int WI = 16;
    localparam int WO = 25;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [WI-1:0] in_data;
    logic                 out_valid;
    logic signed [WO-1:0] out_data;

    int n_total = 0;
    int n_bad   = 0;

    longint q [$];

    // Impulse response of three cascaded length-8 boxcars.
    int h_tab [22] = '{1, 3, 6, 10, 15, 21, 28, 36, 42, 46, 48,
                       48, 46, 42, 36, 28, 21, 15, 10, 6, 3, 1};

    cic_upsample #(.WIDTH_IN(16), .R(8), .M(1), .STAGES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && out_valid) q.push_back(longint'(out_data));
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) nclk();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic send(input int val);
        int cnt;
        cnt      = 0;
        in_valid = 1'b1;
        in_data  = WI'(val);
        while (!in_ready && cnt < 100) begin
            nclk();
            cnt++;
        end
        if (cnt >= 100) chk("send_timeout", cnt, 0);
        nclk();
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n);
        int cnt;
        cnt = 0;
        while (q.size() < n && cnt < 500) begin
            nclk();
            cnt++;
        end
        chk("strobe_count", longint'(q.size() >= n), 1);
    endtask

    // Gapless response to a constant stream of amp, zero-stuffed by 8.
    function automatic longint dc_exp(input int n, input int amp);
        longint s;
        s = 0;
        for (int p = n - 2; p >= 0; p -= 8) begin
            if (p <= 21) s += h_tab[p];
        end
        return s * amp;
    endfunction

    function automatic longint imp_exp(input int n);
        if (n >= 2 && n - 2 <= 21) return h_tab[n-2];
        return 0;
    endfunction

    initial begin
        longint sum;

        // Reset and idle
        do_reset();
        for (int k = 0; k < 20; k++) begin
            nclk();
            chk("idle_ready", in_ready, 1);
            chk("idle_valid", out_valid, 0);
            chk("idle_data", out_data, 0);
        end

        // Impulse
        do_reset();
        send(1);
        for (int k = 0; k < 5; k++) send(0);
        wait_strobes(48);
        sum = 0;
        for (int n = 0; n < 48; n++) begin
            chk($sformatf("imp_%0d", n), q[n], imp_exp(n));
            sum += q[n];
        end
        chk("imp_sum", sum, 512);

        // DC +100 and -100
        do_reset();
        for (int k = 0; k < 8; k++) send(100);
        wait_strobes(64);
        for (int n = 0; n < 64; n++) chk($sformatf("dcp_%0d", n), q[n], dc_exp(n, 100));
        chk("dcp_settled", q[63], 6400);

        do_reset();
        for (int k = 0; k < 8; k++) send(-100);
        wait_strobes(64);
        for (int n = 0; n < 64; n++) chk($sformatf("dcn_%0d", n), q[n], dc_exp(n, -100));
        chk("dcn_settled", q[63], -6400);

        // Handshake with in_valid held high
        do_reset();
        in_valid = 1'b1;
        in_data  = '0;
        for (int k = 0; k < 64; k++) begin
            nclk();
            chk($sformatf("hs_ready_%0d", k), in_ready, longint'(k % 8 == 7));
            chk($sformatf("hs_valid_%0d", k), out_valid, longint'(k >= 1));
        end
        in_valid = 1'b0;

        // Stall between two DC bursts
        do_reset();
        for (int k = 0; k < 4; k++) send(100);
        wait_strobes(32);
        for (int k = 0; k < 10; k++) begin
            nclk();
            chk("gap_valid", out_valid, 0);
            chk("gap_hold", out_data, dc_exp(31, 100));
        end
        for (int k = 0; k < 4; k++) send(100);
        wait_strobes(64);
        repeat (3) nclk();
        chk("stall_count", q.size(), 64);
        for (int n = 0; n < 64; n++) chk($sformatf("stall_%0d", n), q[n], dc_exp(n, 100));

        // Reset mid-operation
        do_reset();
        send(1);
        repeat (4) nclk();
        chk("mid_pre_data", out_data, 3);
        rst = 1'b1;
        nclk();
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        chk("mid_ready", in_ready, 1);
        rst = 1'b0;
        q.delete();
        send(1);
        send(0);
        wait_strobes(10);
        for (int n = 0; n < 10; n++) chk($sformatf("mid_imp_%0d", n), q[n], imp_exp(n));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/cic_upsample.md
Name: cic_upsample

Overview:
- CIC interpolator: the transmit-side counterpart of the team's CIC decimator.
- Accepts one low-rate sample per valid/ready handshake and passes it through a comb section running at the input rate.
- Zero-stuffs the sample by R, then runs it through a cascaded integrator section clocked at clk.
- Emits R output strobes per accepted input sample. It sits between baseband sample sources and high-rate DAC/modulator paths.

Parameters:
- WIDTH_IN, 16, input sample width, signed two's complement.
- R, 8, interpolation ratio. Must be a power of two and ≥2.
- M, 1, differential delay of each comb stage. Must be 1 or 2.
- STAGES, 3, number of comb stages and number of integrator stages. Must be ≥1.
- WIDTH_OUT (localparam), WIDTH_IN+STAGES*clog2(R*M), internal and output width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample present
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  WIDTH_IN  signed input sample
- out_valid  out  1  one-cycle strobe; out_data is a new output sample
- out_data  out  WIDTH_OUT  signed interpolated sample

Behaviour:
- Reset: on rst, all of the following clear to 0: comb delay registers, comb_reg, integrators i[0..STAGES-1], phase, busy and out_valid. As a result out_data=0, out_valid=0 and in_ready=1.
- Reset mid-operation discards all state. The next accept starts from zero history.
- Handshake:
  - in_ready = !busy || (phase==R-1).
  - A sample is accepted only on a cycle where in_valid && in_ready.
  - in_data is ignored on all other cycles.
- Comb section, on accept only:
  - Input is sign-extended to WIDTH_OUT.
  - For each stage s, c_s = c_(s-1) − d_s[M], where d_s is that stage's M-deep delay line. All delay lines shift on accept only.
  - Final comb result is registered into comb_reg. phase<=0 and busy<=1.
- Tick: asserted on every cycle with busy==1.
  - On each tick, x = (phase==0) ? comb_reg : 0.
  - Integrator updates: i[0]<=i[0]+x, and i[j]<=i[j]+i[j-1] using pre-edge values (pipelined).
  - phase increments on each tick.
  - On the tick with phase==R-1: if an accept occurs in the same cycle, comb_reg reloads, phase<=0 and busy stays 1 (back-to-back, no gap). Otherwise busy<=0.
- Stall: with no tick, integrators, phase and out_data hold, and out_valid=0. Stalls do not alter the output sequence, only its timing.
- Output:
  - out_valid<=tick; out_data is i[STAGES-1].
  - Latency: first tick is one cycle after the accepting edge. The n-th output strobe (0-based since reset) carries the integrator response to zero-stuffed input index n−(STAGES−1). The first STAGES−1 strobes after reset are therefore 0.
- Throughput: max one input per R clk cycles. Output strobes are continuous while inputs arrive back-to-back.
- Arithmetic: all comb and integrator arithmetic is modulo 2^WIDTH_OUT. Wrap is intentional, and the final result is exact because WIDTH_OUT covers the full growth. No saturation and no rounding.
- DC gain: (R*M)^STAGES / R.

Test Plan:
- Reset/idle: rst high 3 cycles, then in_valid=0 for 20 cycles -> in_ready=1, out_valid=0, out_data=0 throughout.
- Impulse (R=8, M=1, STAGES=3):
  - Stimulus: in_data=1, then 0s, back-to-back.
  - Required: strobes 0–1 are 0. Strobes 2–9 are 1,3,6,10,15,21,28,36. Thereafter the output follows the exact triple-sum, returning to 0 after the impulse clears the combs.
- DC (R=8, M=1, STAGES=3):
  - Stimulus: constant in_data=100, back-to-back.
  - Required: output settles to 6400 on every strobe. A constant −100 settles to −6400.
- Handshake timing (R=8):
  - Stimulus: in_valid held high continuously.
  - Required: in_ready pulses exactly one cycle in every 8, and out_valid stays high every cycle after the first accept.
- Stall (R=8):
  - Stimulus: 10-cycle gap inserted in in_valid after a DC=100 stream.
  - Required: out_valid=0 during the gap, out_data held. The post-gap sequence is identical to the gapless run when compared strobe-by-strobe.
- Reset mid-operation: assert rst at phase 4 of an impulse response -> next cycle out_valid=0, out_data=0, in_ready=1. A following impulse reproduces the impulse-test values.
